// File: rtl/smaesh_key_stream_pkg.sv
// Shared types and constants for the SMAesH key streamer.
// Key-size encoding matches the smaesh_config KSIZE_* values.
package smaesh_key_stream_pkg;

    localparam int KEY_BITS  = 256;
    localparam int WORD_BITS = 32;

    localparam logic [1:0] KSIZE_128 = 2'b00;
    localparam logic [1:0] KSIZE_192 = 2'b01;
    localparam logic [1:0] KSIZE_256 = 2'b10;

    localparam logic [3:0] WORDS_128 = 4'd4;
    localparam logic [3:0] WORDS_192 = 4'd6;
    localparam logic [3:0] WORDS_256 = 4'd8;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_HOLDER = 3'd1,
        START       = 3'd2,
        STREAM      = 3'd3,
        DONE        = 3'd4
    } state_e;

    // Unknown encodings fall back to the 128-bit word count.
    function automatic logic [3:0] words_per_share(input logic [1:0] ksize);
        case (ksize)
            KSIZE_192: return WORDS_192;
            KSIZE_256: return WORDS_256;
            default:   return WORDS_128;
        endcase
    endfunction

endpackage

// File: rtl/smaesh_key_streamer_if.sv
// Bus bundles around the key streamer.
// smaesh_key_req_if   : host -> streamer load request (master = host).
// smaesh_key_holder_if: streamer -> key holder fetch bus (master = streamer).
// Handshake rule on both buses: a beat transfers on a rising clock edge where
// valid and ready are both high; the source keeps valid and payload stable
// until that edge and never withdraws valid without a transfer.
interface smaesh_key_req_if #(parameter int D = 2);
    logic [D*256-1:0] req_key_shares;
    logic [1:0]       req_key_size;
    logic             req_mode_inverse;
    logic             req_valid;
    logic             req_ready;
    logic             abort;

    modport master (output req_key_shares, req_key_size, req_mode_inverse,
                    req_valid, abort, input req_ready);
    modport slave  (input req_key_shares, req_key_size, req_mode_inverse,
                    req_valid, abort, output req_ready);
endinterface

interface smaesh_key_holder_if;
    logic        holder_busy;
    logic        start_fetch_procedure;
    logic [1:0]  key_size_cfg;
    logic        mode_inverse;
    logic [31:0] data_out;
    logic        data_out_valid;
    logic        data_out_ready;
    logic        done;

    modport master (output start_fetch_procedure, key_size_cfg, mode_inverse,
                    data_out, data_out_valid, done,
                    input holder_busy, data_out_ready);
    modport slave  (input start_fetch_procedure, key_size_cfg, mode_inverse,
                    data_out, data_out_valid, done,
                    output holder_busy, data_out_ready);
endinterface

// File: rtl/smaesh_key_stream_counter.sv
// Share/word position counter for the key streamer. word_idx runs 0..bound
// and then wraps, advancing share_idx; share_idx wraps at D-1 so it never
// leaves the valid share range.
module smaesh_key_stream_counter #(
    parameter  int D  = 2,
    localparam int SW = (D > 1) ? $clog2(D) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_i,
    input  logic [2:0]    bound_i,
    output logic [SW-1:0] share_idx_o,
    output logic [2:0]    word_idx_o,
    output logic          last_o
);

    logic [SW-1:0] share_q, share_d;
    logic [2:0]    word_q, word_d;

    // Next position: clear wins over increment.
    always_comb begin
        share_d = share_q;
        word_d  = word_q;
        if (clr_i) begin
            share_d = '0;
            word_d  = '0;
        end else if (inc_i) begin
            if (word_q == bound_i) begin
                word_d  = '0;
                share_d = (share_q == SW'(D - 1)) ? '0 : share_q + SW'(1);
            end else begin
                word_d = word_q + 3'd1;
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            share_q <= '0;
            word_q  <= '0;
        end else begin
            share_q <= share_d;
            word_q  <= word_d;
        end
    end

    assign share_idx_o = share_q;
    assign word_idx_o  = word_q;
    assign last_o      = (share_q == SW'(D - 1)) && (word_q == bound_i);

endmodule

// File: rtl/smaesh_key_streamer.sv
// Key streamer: captures a d-share key and streams it word by word to the
// SMAesH key holder after a start_fetch_procedure pulse.
// Optional feature macro: KEY_STREAM_ZEROIZE_EN (wipes the key register after
// DONE/abort and forces data_out to 0 while not valid).
module smaesh_key_streamer
    import smaesh_key_stream_pkg::*;
#(
    parameter int D = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    smaesh_key_req_if.slave       req,
    smaesh_key_holder_if.master   hold,
    output state_e                dbg_state_o
);

    localparam int SW = (D > 1) ? $clog2(D) : 1;

    state_e                  state_q;
    logic                    req_ready_q;
    logic                    start_q;
    logic                    valid_q;
    logic                    done_q;
    logic [D*KEY_BITS-1:0]   key_q;
    logic [1:0]              ksize_q;
    logic                    mode_q;

    logic                    req_fire;
    logic                    xfer;
    logic                    abort_act;
    logic                    cnt_clr;
    logic                    cnt_inc;
    logic                    cnt_last;
    logic [2:0]              bound;
    logic [SW-1:0]           share_idx;
    logic [2:0]              word_idx;
    logic [WORD_BITS-1:0]    key_word;

    assign req_fire  = req.req_valid & req_ready_q;
    assign xfer      = valid_q & hold.data_out_ready;
    assign abort_act = req.abort & (state_q != IDLE);
    assign bound     = 3'(words_per_share(ksize_q) - 4'd1);

    // Aborted words do not count as sent; restart position on every new load.
    assign cnt_clr = req_fire | abort_act | (state_q == DONE);
    assign cnt_inc = xfer & ~abort_act;

    smaesh_key_stream_counter #(.D(D)) u_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (cnt_clr),
        .inc_i       (cnt_inc),
        .bound_i     (bound),
        .share_idx_o (share_idx),
        .word_idx_o  (word_idx),
        .last_o      (cnt_last)
    );

    // Control FSM with registered handshake/strobe outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            start_q     <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else if (abort_act) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            start_q     <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_fire) begin
                        req_ready_q <= 1'b0;
                        state_q     <= WAIT_HOLDER;
                    end
                end
                WAIT_HOLDER: begin
                    if (!hold.holder_busy) begin
                        start_q <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    start_q <= 1'b0;
                    valid_q <= 1'b1;
                    state_q <= STREAM;
                end
                STREAM: begin
                    if (xfer && cnt_last) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b0;
                    start_q     <= 1'b0;
                    valid_q     <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    // Key/config capture on a load handshake (optionally wiped after use).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q   <= '0;
            ksize_q <= 2'b00;
            mode_q  <= 1'b0;
        end else if (req_fire) begin
            key_q   <= req.req_key_shares;
            ksize_q <= req.req_key_size;
            mode_q  <= req.req_mode_inverse;
`ifdef KEY_STREAM_ZEROIZE_EN
        end else if ((state_q == DONE) || abort_act) begin
            key_q <= '0;
`endif
        end
    end

    // Word w of share s sits at bit offset 256*s + 32*w.
    assign key_word = key_q[{share_idx, word_idx, 5'b00000} +: WORD_BITS];

`ifdef KEY_STREAM_ZEROIZE_EN
    assign hold.data_out = valid_q ? key_word : '0;
`else
    assign hold.data_out = key_word;
`endif

    assign req.req_ready              = req_ready_q;
    assign hold.start_fetch_procedure = start_q;
    assign hold.data_out_valid        = valid_q;
    assign hold.done                  = done_q;
    assign hold.key_size_cfg          = ksize_q;
    assign hold.mode_inverse          = mode_q;
    assign dbg_state_o                = state_q;

endmodule

// File: tb/tb_smaesh_key_streamer.sv
// Directed bench for smaesh_key_streamer (d = 2): expected words are queued
// at load time from the bench's own key vectors and popped on each accepted
// holder transfer.
module tb_smaesh_key_streamer;
    import smaesh_key_stream_pkg::*;

    logic clk;
    logic rst_n;
    state_e dbg_state;

    smaesh_key_req_if #(.D(2)) rq ();
    smaesh_key_holder_if       hd ();

    smaesh_key_streamer #(.D(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (rq),
        .hold        (hd),
        .dbg_state_o (dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int words_of(input logic [1:0] ks);
        if (ks == 2'b01) return 6;
        if (ks == 2'b10) return 8;
        return 4;
    endfunction

    // Present one load request and queue the words it must produce.
    task automatic do_load(input logic [511:0] k, input logic [1:0] ks, input logic mi);
        int n;
        n = 0;
        @(negedge clk);
        while (!rq.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", 32'(rq.req_ready), 32'd1);
        rq.req_key_shares   = k;
        rq.req_key_size     = ks;
        rq.req_mode_inverse = mi;
        rq.req_valid        = 1'b1;
        @(posedge clk);
        #1;
        rq.req_valid = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < words_of(ks); w++)
                exp_q.push_back(k[256*s + 32*w +: 32]);
    endtask

    // Cycle-by-cycle holder model. rdy_mode 0: ready always, 1: every other cycle.
    task automatic run_xfer(input int rdy_mode, input int busy_cycles, input int abort_at,
                            input int stop_at, input int exp_words,
                            input logic [1:0] exp_cfg, input logic exp_mi);
        int start_it, first_valid_it, xfers, n_start, n_done, last_xfer_it, abort_it, done_it;
        logic pv, pr, rdy, ab, will;
        logic [31:0] pd;
        start_it = -1; first_valid_it = -1; xfers = 0; n_start = 0; n_done = 0;
        last_xfer_it = -1; abort_it = -1; done_it = -1;
        pv = 1'b0; pr = 1'b0; pd = '0;
        for (int it = 1; it <= 400; it++) begin
            rdy = (rdy_mode == 0) ? 1'b1 : ((it % 2) == 0);
            hd.holder_busy    = (it <= busy_cycles);
            hd.data_out_ready = rdy;
            will = hd.data_out_valid && rdy;
            ab = (abort_at > 0) && will && (xfers + 1 == abort_at);
            rq.abort = ab;
            @(negedge clk);
            if (hd.start_fetch_procedure) begin
                n_start++;
                if (start_it < 0) start_it = it;
                check("start_cfg", 32'(hd.key_size_cfg), 32'(exp_cfg));
                check("start_mode", 32'(hd.mode_inverse), 32'(exp_mi));
            end
            if (hd.data_out_valid) begin
                if (first_valid_it < 0) first_valid_it = it;
                if (pv && !pr) check("hold_stable", hd.data_out, pd);
                if (rdy && !ab) begin
                    xfers++;
                    last_xfer_it = it;
                    if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
                    else check("word", hd.data_out, exp_q.pop_front());
                end
            end
            if (hd.done) begin
                n_done++;
                done_it = it;
                check("done_timing", 32'(it), 32'(last_xfer_it + 1));
            end
            if (abort_it > 0 && it == abort_it + 1) begin
                check("abort_valid_low", 32'(hd.data_out_valid), 32'd0);
                check("abort_req_ready", 32'(rq.req_ready), 32'd1);
                check("abort_state", 32'(dbg_state), 32'(IDLE));
`ifdef KEY_STREAM_ZEROIZE_EN
                check("abort_key_zero", 32'(dut.key_q == '0), 32'd1);
                check("abort_data_zero", hd.data_out, 32'd0);
`endif
            end
            pv = hd.data_out_valid;
            pr = rdy;
            pd = hd.data_out;
            if (ab) abort_it = it;
            @(posedge clk);
            #1;
            rq.abort = 1'b0;
            if (stop_at > 0 && xfers == stop_at) break;
            if (done_it > 0 && it == done_it + 2) break;
            if (abort_it > 0 && it == abort_it + 3) break;
        end
        hd.holder_busy = 1'b0;
        if (stop_at > 0) begin
            check("stop_reached", 32'(xfers), 32'(stop_at));
        end else begin
            check("n_start", 32'(n_start), 32'd1);
            check("start_latency", 32'(start_it), 32'(busy_cycles + 2));
            check("first_valid", 32'(first_valid_it), 32'(start_it + 1));
            if (abort_at > 0) begin
                check("abort_no_done", 32'(n_done), 32'd0);
                check("abort_xfers", 32'(xfers), 32'(abort_at - 1));
                exp_q.delete();
            end else begin
                check("n_done", 32'(n_done), 32'd1);
                check("n_xfers", 32'(xfers), 32'(exp_words));
                check("sb_empty", 32'(exp_q.size()), 32'd0);
            end
        end
    endtask

    logic [511:0] key_a, key_b;

    initial begin
        // Reset phase.
        rst_n = 1'b0;
        rq.req_key_shares = '0; rq.req_key_size = 2'b00; rq.req_mode_inverse = 1'b0;
        rq.req_valid = 1'b0; rq.abort = 1'b0;
        hd.holder_busy = 1'b0; hd.data_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(rq.req_ready), 32'd0);
        check("rst_start", 32'(hd.start_fetch_procedure), 32'd0);
        check("rst_valid", 32'(hd.data_out_valid), 32'd0);
        check("rst_done", 32'(hd.done), 32'd0);
        check("rst_data", hd.data_out, 32'd0);
        check("rst_cfg", 32'({hd.key_size_cfg, hd.mode_inverse}), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;

        // 128-bit load, ready always high.
        key_a = '0;
        key_a[127:0]   = 128'h000102030405060708090A0B0C0D0E0F;
        key_a[383:256] = 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;
        do_load(key_a, KSIZE_128, 1'b0);
        run_xfer(0, 0, 0, 0, 8, KSIZE_128, 1'b0);

        // 256-bit load, ready every other cycle, inverse mode.
        for (int i = 0; i < 16; i++) key_b[32*i +: 32] = $urandom;
        do_load(key_b, KSIZE_256, 1'b1);
        run_xfer(1, 0, 0, 0, 16, KSIZE_256, 1'b1);

        // 192-bit load while the holder stays busy for 10 cycles.
        for (int i = 0; i < 16; i++) key_b[32*i +: 32] = $urandom_range(32'hFFFF_FFFF, 0);
        hd.holder_busy = 1'b1;
        do_load(key_b, KSIZE_192, 1'b0);
        run_xfer(0, 10, 0, 0, 12, KSIZE_192, 1'b0);

        // Reserved encoding 2'b11 streams like 128.
        for (int i = 0; i < 16; i++) key_b[32*i +: 32] = $urandom;
        do_load(key_b, 2'b11, 1'b1);
        run_xfer(0, 0, 0, 0, 8, 2'b11, 1'b1);

        // Abort on the 5th accepted word of a 256-bit load.
        for (int i = 0; i < 16; i++) key_b[32*i +: 32] = $urandom;
        do_load(key_b, KSIZE_256, 1'b0);
        run_xfer(0, 0, 5, 0, 16, KSIZE_256, 1'b0);

        // Reset mid-stream, then a fresh load must restart at share 0 word 0.
        for (int i = 0; i < 16; i++) key_b[32*i +: 32] = $urandom;
        do_load(key_b, KSIZE_256, 1'b0);
        run_xfer(0, 0, 0, 3, 16, KSIZE_256, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(hd.data_out_valid), 32'd0);
        check("midrst_done", 32'(hd.done), 32'd0);
        check("midrst_start", 32'(hd.start_fetch_procedure), 32'd0);
        check("midrst_req_ready", 32'(rq.req_ready), 32'd0);
        check("midrst_data", hd.data_out, 32'd0);
        check("midrst_state", 32'(dbg_state), 32'(IDLE));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        do_load(key_a, KSIZE_128, 1'b0);
        run_xfer(0, 0, 0, 0, 8, KSIZE_128, 1'b0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
